// File: rtl/instruction_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_queue_if : fetch/decode side signals of the instruction queue
// Revision 1.0
// ---------------------------------------------------------------------------
interface instruction_queue_if #(
   parameter int DEPTH = 4
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic              fetchPush;
   logic [31:0]       fetchInstruction;
   logic [29:0]       fetchProgramCounter;
   logic [29:0]       fetchLinkAddress;
   logic              fetchValidInstruction;
   logic              fetchHold;
   logic              flush;
   logic              decodeStall;
   logic [31:0]       instruction;
   logic [29:0]       programCounter;
   logic [29:0]       linkAddress;
   logic              validInstruction;
   logic              instructionAvailable;
   logic [OCC_W-1:0]  occupancy;

   modport master (
      output fetchPush, fetchInstruction, fetchProgramCounter, fetchLinkAddress,
             fetchValidInstruction, flush, decodeStall,
      input  fetchHold, instruction, programCounter, linkAddress,
             validInstruction, instructionAvailable, occupancy
   );

   modport slave (
      input  fetchPush, fetchInstruction, fetchProgramCounter, fetchLinkAddress,
             fetchValidInstruction, flush, decodeStall,
      output fetchHold, instruction, programCounter, linkAddress,
             validInstruction, instructionAvailable, occupancy
   );
endinterface
`default_nettype wire

// File: rtl/instruction_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_queue : circular-buffer FIFO decoupling fetch from decode
// Revision 1.0
// ---------------------------------------------------------------------------
module instruction_queue #(
   parameter int          DEPTH           = 4,
   parameter logic [31:0] NOP_INSTRUCTION = 32'h1500FFFF
) (
   input  logic               cpuClock,
   input  logic               cpuResetN,
   instruction_queue_if.slave q
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int OCC_W   = PTR_W + 1;
   localparam int ENTRY_W = 32 + 30 + 30 + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic               avail, full, pop, push, hold;
   logic [ENTRY_W-1:0] head;

   // Hold drops combinationally when decode consumes, so a full queue can
   // accept and release an entry in the same cycle.
   always_comb begin
      avail = (occ_q != '0);
      full  = (occ_q == OCC_W'(DEPTH));
      pop   = avail & ~q.decodeStall & ~q.flush;
      hold  = full & ~pop;
      push  = q.fetchPush & ~hold & ~q.flush;
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (q.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
         occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
      end
   end

   always_ff @(posedge cpuClock or negedge cpuResetN) begin
      if (!cpuResetN) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge cpuClock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {q.fetchInstruction, q.fetchProgramCounter,
                             q.fetchLinkAddress, q.fetchValidInstruction};
      end
   end

   always_comb begin
      head                   = mem_q[rd_ptr_q];
      q.fetchHold            = hold;
      q.instructionAvailable = avail;
      q.occupancy            = occ_q;
      q.instruction          = NOP_INSTRUCTION;
      q.programCounter       = '0;
      q.linkAddress          = '0;
      q.validInstruction     = 1'b1;
      if (avail) begin
         q.instruction      = head[92:61];
         q.programCounter   = head[60:31];
         q.linkAddress      = head[30:1];
         q.validInstruction = head[0];
      end
   end

   a_no_push_on_hold: assert property (@(posedge cpuClock) disable iff (!cpuResetN)
      !(q.fetchPush && q.fetchHold))
      else $warning("instruction_queue: fetchPush while fetchHold, entry dropped");

endmodule
`default_nettype wire
